usb_tx_arb: RTL
===============

// Module: usb_tx_arb
// PURPOSE
// - N-channel packet-locked TX arbiter + output FIFO; successor to the 2-source TOKEN/DATA TX mux.
// - Sits between link-layer packet sources (crc5 token/handshake, data, ...) and the PHY TX port.
// - Grants one source per packet (sop..eop); never interleaves beats from different sources.
// - DEPTH-entry FIFO decouples PHY backpressure; a cancel beat terminates the packet.
// PARAMETERS
// - NCH    2  number of source channels (>=2)
// - DW     8  data width per beat
// - DEPTH  4  output FIFO entries (power of 2, >=2)
// PORTS
// - clk        in   1       clock
// - rst_n      in   1       reset, asynchronous, active-low
// - in_sop     in   NCH     per-channel start of packet
// - in_eop     in   NCH     per-channel end of packet
// - in_cancel  in   NCH     per-channel abort; beat carrying it ends packet
// - in_valid   in   NCH     per-channel beat valid
// - in_ready   out  NCH     per-channel beat accept
// - in_data    in   NCH*DW  channel k at [k*DW +: DW]
// - out_sop    out  1       PHY start of packet
// - out_eop    out  1       PHY end of packet
// - out_cancel out  1       PHY abort flag
// - out_valid  out  1       PHY beat valid (FIFO not empty)
// - out_ready  in   1       PHY accept
// - out_data   out  DW      PHY data
// - grant      out  NCH     one-hot current owner, 0 when IDLE
// - busy       out  1       FSM in LOCK or FIFO not empty
// - eop_en     out  1       pulse: out_valid & out_ready & out_sop
// BEHAVIOUR
// - Reset: state IDLE, grant=0, FIFO empty, out_valid=0, out_sop/eop/cancel=0, out_data=0, in_ready=0.
// - FSM IDLE: requesters = in_valid & in_sop; if any, register winner into grant, go LOCK.
//   in_ready=0 in IDLE except channels with valid & ~sop: ready=1, beat discarded (stray drain).
// - FSM LOCK: in_ready[k] = grant[k] & ~fifo_full; all other channels 0.
//   accepted beat {sop,eop,cancel,data} written to FIFO same edge.
//   accepted beat with eop|cancel -> IDLE, grant=0 next cycle (one idle cycle between packets).
// - Latency: sop asserted in IDLE at cycle 0 -> grant cycle 1 -> accepted cycle 1 -> out_valid cycle 2.
// - FIFO: wr/rd pointers log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ, low bits equal.
//   out_* driven from head entry; head advances on out_valid & out_ready.
//   read and write same cycle: count unchanged; write while full never happens (ready=0).
//   out_data/flags hold last value when empty; out_valid=0.
// - Owner dropping in_valid mid-packet: stay LOCK, wait; no timeout.
// - sop on granted channel mid-packet: stored as-is, no re-arbitration.
// - Simultaneous sop on several channels: exactly one granted per arbitration policy.
// - Async reset mid-packet: FIFO content discarded, partial packet lost, IDLE.
// CONFIGURATION
// - USB_TX_ARB_RR_EN defined: round-robin; last-grant pointer (reset NCH-1), search starts at ptr+1 mod NCH;
//   pointer updated on every grant.
// - Undefined: fixed priority, lowest index wins; no pointer register.
// TESTING
// - Single pkt ch0: sop=1 d=A5, d=5A, eop d=3C, out_ready=1 -> out A5,5A,3C; eop_en 1 cycle at A5.
// - ch0,ch1 sop same cycle, 3-beat pkts, repeat twice -> fixed: ch0,ch0,...; RR_EN: ch0,ch1,ch0,ch1.
// - out_ready=0 for 10 cycles, DEPTH=4, 6-beat pkt -> exactly 4 accepted, in_ready=0, no loss.
// - ch1 cancel on beat 2 of 5 -> out_cancel=1 on beat 2, grant=0 next cycle, later ch1 beats need new sop.
// - rst_n low while 2 beats in FIFO -> out_valid=0, grant=0 immediately; next pkt transfers clean.
// - ch1 valid without sop in IDLE -> in_ready[1]=1, beat never appears on out_*.

Source files
------------

// File: rtl/usb_tx_arb.sv
// usb_tx_arb: N-channel packet-locked TX arbiter with a DEPTH-entry output FIFO.
// Latency: sop seen in IDLE at cycle 0 -> grant and first beat accepted at cycle 1 -> out_valid at cycle 2.
// Backpressure: the owner's in_ready drops while the FIFO is full; the FIFO drains on out_valid & out_ready.
//
// Arbitration policy is selected by the macro USB_TX_ARB_RR_EN:
//   defined   -> round-robin from a last-grant pointer (reset NCH-1)
//   undefined -> fixed priority, lowest channel index wins
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_sop/eop/cancel/valid [NCH]  per-channel beat qualifiers
//   in_ready [NCH]                 per-channel beat accept
//   in_data [NCH*DW]               channel k at [k*DW +: DW]
//   out_sop/eop/cancel/valid/data  PHY side, driven from the FIFO head
//   out_ready                      PHY accept
//   grant [NCH]                    one-hot current owner, 0 when idle
//   busy                           packet locked or FIFO not empty
//   eop_en                         pulse on an accepted sop beat at the PHY
module usb_tx_arb #(
  parameter int NCH   = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_sop,
  input  logic [NCH-1:0]    in_eop,
  input  logic [NCH-1:0]    in_cancel,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH*DW-1:0] in_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_cancel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [NCH-1:0]    grant,
  output logic              busy,
  output logic              eop_en
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, LOCK} state_t;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic          cancel;
    logic [DW-1:0] data;
  } beat_t;

  state_t         state, state_nxt;
  logic [NCH-1:0] grant_nxt;
  logic [NCH-1:0] req;
  logic [NCH-1:0] win;
  logic           found;

  // FIFO
  beat_t          mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           fifo_full, fifo_empty;
  logic           wr_en, rd_en;
  beat_t          wr_beat;
  beat_t          last_beat;
  beat_t          head;

  assign req = in_valid & in_sop;

`ifdef USB_TX_ARB_RR_EN
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_idx;

  // Two passes: first the channels above the last winner, then wrap to the lowest index.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && req[k] && (k > int'(rr_ptr))) begin
        found   = 1'b1;
        win[k]  = 1'b1;
        win_idx = PW'(k);
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (!found && req[k]) begin
        found   = 1'b1;
        win[k]  = 1'b1;
        win_idx = PW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PW'(NCH - 1);
    end else if (state == IDLE && found) begin
      rr_ptr <= win_idx;
    end
  end
`else
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && req[k]) begin
        found  = 1'b1;
        win[k] = 1'b1;
      end
    end
  end
`endif

  // Beat offered by the current owner (all-zero when nobody is granted).
  beat_t sel_beat;
  always_comb begin
    sel_beat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant[k]) begin
        sel_beat.sop    = in_sop[k];
        sel_beat.eop    = in_eop[k];
        sel_beat.cancel = in_cancel[k];
        sel_beat.data   = in_data[k*DW +: DW];
      end
    end
  end

  // FSM next state and handshake
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    in_ready  = '0;
    wr_en     = 1'b0;
    wr_beat   = sel_beat;
    case (state)
      IDLE: begin
        // Beats without sop arriving between packets are orphans: drain them.
        in_ready = in_valid & ~in_sop;
        if (found) begin
          grant_nxt = win;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        in_ready = grant & {NCH{~fifo_full}};
        wr_en    = |(in_valid & in_ready);
        if (wr_en && (sel_beat.eop || sel_beat.cancel)) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en      = ~fifo_empty & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_beat <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_beat <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_beat;
    end
  end

  // When empty, the outputs keep showing the last beat handed to the PHY.
  assign head       = fifo_empty ? last_beat : mem[rd_ptr[AW-1:0]];
  assign out_valid  = ~fifo_empty;
  assign out_sop    = head.sop;
  assign out_eop    = head.eop;
  assign out_cancel = head.cancel;
  assign out_data   = head.data;

  assign eop_en = out_valid & out_ready & out_sop;
  assign busy   = (state == LOCK) | ~fifo_empty;

endmodule
